// File: rtl/spi_host_master.sv
// SPI mode-0 host initiator: turns one read/write request (10-bit address, 8-bit data)
// into a 24-bit frame and captures the returned read byte.
module spi_host_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_start,
    input  logic       i_write,
    input  logic [9:0] i_addr,
    input  logic [7:0] i_wdata,
    input  logic       i_miso,
    output logic       o_sclk,
    output logic       o_ssn,
    output logic       o_mosi,
    output logic       o_busy,
    output logic       o_done,
    output logic [7:0] o_rdata
);

    localparam int HW = $clog2(CLK_DIV);
    localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

    state_t        state, state_n;
    logic [HW-1:0] hcnt, hcnt_n;
    logic [4:0]    bcnt, bcnt_n;
    logic          high, high_n;
    logic [23:0]   tx, tx_n;
    logic [7:0]    rx, rx_n;
    logic          is_write, is_write_n;
    logic          sclk_n, ssn_n, mosi_n, busy_n, done_n;
    logic [7:0]    rdata_n;
    logic          half_end;

    assign half_end = (hcnt == HALF_LAST);

    // State register; outputs are registered from next-state values so they line up with the state
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            hcnt     <= '0;
            bcnt     <= '0;
            high     <= 1'b0;
            tx       <= '0;
            rx       <= '0;
            is_write <= 1'b0;
            o_sclk   <= 1'b0;
            o_ssn    <= 1'b1;
            o_mosi   <= 1'b0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_rdata  <= 8'h00;
        end else begin
            state    <= state_n;
            hcnt     <= hcnt_n;
            bcnt     <= bcnt_n;
            high     <= high_n;
            tx       <= tx_n;
            rx       <= rx_n;
            is_write <= is_write_n;
            o_sclk   <= sclk_n;
            o_ssn    <= ssn_n;
            o_mosi   <= mosi_n;
            o_busy   <= busy_n;
            o_done   <= done_n;
            o_rdata  <= rdata_n;
        end
    end

    // Next-state logic: each SHIFT bit is a high half then a low half, D cycles apiece
    always_comb begin
        state_n    = state;
        hcnt_n     = hcnt;
        bcnt_n     = bcnt;
        high_n     = high;
        tx_n       = tx;
        rx_n       = rx;
        is_write_n = is_write;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_n    = SETUP;
                    hcnt_n     = '0;
                    bcnt_n     = '0;
                    high_n     = 1'b0;
                    is_write_n = i_write;
                    tx_n       = {i_write, 5'b00000, i_addr, (i_write ? i_wdata : 8'h00)};
                end
            end
            SETUP: begin
                if (half_end) begin
                    state_n = SHIFT;
                    hcnt_n  = '0;
                    high_n  = 1'b1;
                    bcnt_n  = '0;
                end else begin
                    hcnt_n = hcnt + 1'b1;
                end
            end
            SHIFT: begin
                // Sample MISO in the cycle SCLK is seen high for the first time
                if (high && hcnt == '0) begin
                    rx_n = {rx[6:0], i_miso};
                end
                if (half_end) begin
                    hcnt_n = '0;
                    if (high) begin
                        high_n = 1'b0;
                        tx_n   = {tx[22:0], 1'b0};
                    end else if (bcnt == 5'd23) begin
                        state_n = GAP;
                    end else begin
                        bcnt_n = bcnt + 1'b1;
                        high_n = 1'b1;
                    end
                end else begin
                    hcnt_n = hcnt + 1'b1;
                end
            end
            GAP: begin
                if (half_end) begin
                    state_n = IDLE;
                    hcnt_n  = '0;
                end else begin
                    hcnt_n = hcnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Output decode from the upcoming state
    always_comb begin
        sclk_n  = (state_n == SHIFT) && high_n;
        ssn_n   = !((state_n == SETUP) || (state_n == SHIFT));
        mosi_n  = ssn_n ? 1'b0 : tx_n[23];
        busy_n  = (state_n != IDLE);
        done_n  = (state == GAP) && (state_n == IDLE);
        rdata_n = (done_n && !is_write) ? rx : o_rdata;
    end

endmodule

// File: tb/tb_spi_host_master.sv
// Bench for spi_host_master: directed and random frames on CLK_DIV=4 and CLK_DIV=2
// instances, checked against a word-level frame model and an SPI slave model.
module tb_spi_host_master;

    logic       clk = 1'b0;
    logic       reset, i_start, i_write, i_miso;
    logic [9:0] i_addr;
    logic [7:0] i_wdata;
    logic       sel;

    logic       start4, sclk4, ssn4, mosi4, busy4, done4;
    logic       start2, sclk2, ssn2, mosi2, busy2, done2;
    logic [7:0] rdata4, rdata2;
    logic       sclk, ssn, mosi, busy, done;
    logic [7:0] rdata;

    int checks = 0;
    int fails = 0;
    int d_div;

    int          cyc, rises, ssn_first, ssn_last, done_cyc, done_cnt;
    logic [23:0] mosi_word;
    logic        prev_sclk;
    logic [7:0]  slave_byte;
    logic [7:0]  model_rdata;

    always #5 clk = ~clk;

    assign start4 = i_start & ~sel;
    assign start2 = i_start & sel;
    assign sclk   = sel ? sclk2  : sclk4;
    assign ssn    = sel ? ssn2   : ssn4;
    assign mosi   = sel ? mosi2  : mosi4;
    assign busy   = sel ? busy2  : busy4;
    assign done   = sel ? done2  : done4;
    assign rdata  = sel ? rdata2 : rdata4;

    spi_host_master #(.CLK_DIV(4)) u_dut4 (
        .clk(clk), .reset(reset), .i_start(start4), .i_write(i_write), .i_addr(i_addr),
        .i_wdata(i_wdata), .i_miso(i_miso), .o_sclk(sclk4), .o_ssn(ssn4), .o_mosi(mosi4),
        .o_busy(busy4), .o_done(done4), .o_rdata(rdata4)
    );

    spi_host_master #(.CLK_DIV(2)) u_dut2 (
        .clk(clk), .reset(reset), .i_start(start2), .i_write(i_write), .i_addr(i_addr),
        .i_wdata(i_wdata), .i_miso(i_miso), .o_sclk(sclk2), .o_ssn(ssn2), .o_mosi(mosi2),
        .o_busy(busy2), .o_done(done2), .o_rdata(rdata2)
    );

    // Frame word as the slave should see it: R/W at bit 23, address at 17:8, data only for writes
    function automatic logic [23:0] model_word(input logic w, input logic [9:0] a, input logic [7:0] d);
        int v;
        v = int'(a) * 256;
        if (w) v = v + 8388608 + int'(d);
        return 24'(v);
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic reset_monitor();
        cyc       = 0;
        rises     = 0;
        ssn_first = -1;
        ssn_last  = -1;
        done_cyc  = -1;
        done_cnt  = 0;
        mosi_word = '0;
        prev_sclk = 1'b0;
    endtask

    // One system cycle: observe outputs 1 time unit after the edge, then play the slave
    task automatic tick();
        int idx;
        @(posedge clk);
        #1;
        cyc++;
        if (sclk && !prev_sclk) begin
            mosi_word = {mosi_word[22:0], mosi};
            rises++;
        end
        prev_sclk = sclk;
        if (!ssn) begin
            if (ssn_first < 0) ssn_first = cyc;
            ssn_last = cyc;
        end
        if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
        end
        if (!sclk) begin
            idx = 23 - rises;
            if (rises >= 16 && rises < 24) i_miso = slave_byte[idx[2:0]];
            else i_miso = 1'($urandom);
        end
    endtask

    task automatic apply_stimulus(input logic w, input logic [9:0] a, input logic [7:0] d, input logic [7:0] sb);
        i_start    = 1'b1;
        i_write    = w;
        i_addr     = a;
        i_wdata    = d;
        slave_byte = sb;
        reset_monitor();
    endtask

    task automatic wait_done();
        int limit;
        limit = 54 * d_div + 1;
        while (done_cnt == 0 && cyc < limit) tick();
        check_output("done_seen", 32'(done_cnt), 32'd1);
    endtask

    // Complete frame with full frame-level checks; leaves the bench at the done cycle
    task automatic do_frame(input logic w, input logic [9:0] a, input logic [7:0] d, input logic [7:0] sb);
        logic [23:0] exp_word;
        exp_word = model_word(w, a, d);
        apply_stimulus(w, a, d, sb);
        tick();
        i_start = 1'b0;
        check_output("c1_busy", 32'(busy), 32'd1);
        check_output("c1_ssn", 32'(ssn), 32'd0);
        check_output("c1_mosi", 32'(mosi), 32'(exp_word[23]));
        wait_done();
        if (!w) model_rdata = sb;
        check_output("done_cycle", 32'(done_cyc), 32'(50 * d_div + 1));
        check_output("mosi_word", 32'(mosi_word), 32'(exp_word));
        check_output("sclk_rises", 32'(rises), 32'd24);
        check_output("ssn_first", 32'(ssn_first), 32'd1);
        check_output("ssn_last", 32'(ssn_last), 32'(49 * d_div));
        check_output("done_busy", 32'(busy), 32'd0);
        check_output("rdata", 32'(rdata), 32'(model_rdata));
    endtask

    initial begin
        int ssn_last1, done1;
        logic [7:0] sb;
        logic [23:0] first_word;

        sel = 1'b0; d_div = 4;
        reset = 1'b1; i_start = 1'b0; i_write = 1'b0; i_addr = '0; i_wdata = '0; i_miso = 1'b0;
        slave_byte = '0; model_rdata = 8'h00;
        reset_monitor();
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_sclk", 32'(sclk), 32'd0);
        check_output("rst_ssn", 32'(ssn), 32'd1);
        check_output("rst_mosi", 32'(mosi), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_done", 32'(done), 32'd0);
        check_output("rst_rdata", 32'(rdata), 32'h00);
        reset = 1'b0;
        tick();

        $display("[TB] write frame D=4");
        do_frame(1'b1, 10'd1023, 8'h01, 8'h5A);
        check_output("write_word_lit", 32'(mosi_word), 32'h83FF01);
        check_output("write_done_lit", 32'(done_cyc), 32'd201);
        tick();

        $display("[TB] read frame D=4");
        do_frame(1'b0, 10'd1020, 8'hFF, 8'h96);
        check_output("read_word_lit", 32'(mosi_word), 32'h03FC00);
        check_output("read_rdata_lit", 32'(rdata), 32'h96);
        tick();

        $display("[TB] start while busy");
        first_word = model_word(1'b1, 10'h155, 8'hA5);
        apply_stimulus(1'b1, 10'h155, 8'hA5, 8'h00);
        tick();
        i_start = 1'b0;
        while (cyc < 50) tick();
        check_output("busy_at_50", 32'(busy), 32'd1);
        i_start = 1'b1; i_write = 1'b0; i_addr = 10'h2AA; i_wdata = 8'h3C;
        tick();
        i_start = 1'b0;
        wait_done();
        check_output("busy_done_cycle", 32'(done_cyc), 32'(50 * d_div + 1));
        repeat (10) tick();
        check_output("busy_done_count", 32'(done_cnt), 32'd1);
        check_output("busy_word", 32'(mosi_word), 32'(first_word));
        check_output("busy_idle_after", 32'(busy), 32'd0);
        check_output("busy_rdata", 32'(rdata), 32'(model_rdata));

        $display("[TB] back-to-back");
        sb = 8'($urandom);
        apply_stimulus(1'b0, 10'd1000, 8'h00, sb);
        tick();
        i_write = 1'b1; i_addr = 10'd1001; i_wdata = 8'h40;
        wait_done();
        model_rdata = sb;
        check_output("b2b_done1", 32'(done_cyc), 32'(50 * d_div + 1));
        check_output("b2b_word1", 32'(mosi_word), 32'h03E800);
        check_output("b2b_rdata1", 32'(rdata), 32'(sb));
        ssn_last1 = ssn_last;
        done1 = done_cyc;
        slave_byte = 8'($urandom);
        reset_monitor();
        tick();
        i_start = 1'b0;
        check_output("b2b_accept_busy", 32'(busy), 32'd1);
        check_output("b2b_accept_ssn", 32'(ssn), 32'd0);
        // Select is high through the GAP half-period and the done/accept cycle
        check_output("b2b_ssn_high", 32'(done1 - ssn_last1), 32'(d_div + 1));
        wait_done();
        check_output("b2b_done2", 32'(done_cyc), 32'(50 * d_div + 1));
        check_output("b2b_word2", 32'(mosi_word), 32'h83E940);
        check_output("b2b_rdata2", 32'(rdata), 32'(model_rdata));
        tick();

        $display("[TB] reset mid-frame");
        apply_stimulus(1'b1, 10'($urandom), 8'($urandom), 8'h00);
        tick();
        i_start = 1'b0;
        while (cyc < 100) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_output("rstmid_ssn", 32'(ssn), 32'd1);
        check_output("rstmid_sclk", 32'(sclk), 32'd0);
        check_output("rstmid_busy", 32'(busy), 32'd0);
        repeat (60 * d_div) tick();
        check_output("rstmid_no_done", 32'(done_cnt), 32'd0);
        do_frame(1'b0, 10'($urandom), 8'($urandom), 8'($urandom));
        tick();

        $display("[TB] random frames D=4");
        for (int i = 0; i < 4; i++) begin
            do_frame(1'($urandom), 10'($urandom), 8'($urandom), 8'($urandom));
            repeat (1 + $urandom_range(0, 3)) tick();
        end

        $display("[TB] CLK_DIV=2");
        sel = 1'b1; d_div = 2; model_rdata = 8'h00;
        tick();
        do_frame(1'b1, 10'd1023, 8'h01, 8'h00);
        check_output("d2_word_lit", 32'(mosi_word), 32'h83FF01);
        check_output("d2_done_lit", 32'(done_cyc), 32'd101);
        tick();
        for (int i = 0; i < 3; i++) begin
            do_frame(1'($urandom), 10'($urandom), 8'($urandom), 8'($urandom));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
